inst_fetch_mem: RTL and testbench
=================================

# inst_fetch_mem

Parametrised instruction memory for the MIPS pipeline fetch stage, generalising the fixed 32-entry combinational InstMem. Serves one word-aligned fetch per cycle through a valid/ready request/response handshake, and returns the instruction one cycle after the request is accepted. A flush input discards an in-flight fetch on a taken branch. A load port rewrites the program at run time, and an optional boot sequencer preloads the standard test program after reset.

## Interface
- DATA_W, 32, instruction width in bits
- DEPTH, 64, number of words; must be a power of two, ≥ 8
- ADDR_W, 32, PC/byte-address width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  fetch request valid
- req_ready  output  1  fetch request accepted this cycle if also valid
- req_pc  input  ADDR_W  byte address of the fetch
- rsp_valid  output  1  response valid
- rsp_ready  input  1  downstream (IF/ID) accepts response
- rsp_inst  output  DATA_W  fetched instruction
- rsp_fault  output  1  misaligned or out-of-range fetch
- flush  input  1  discard pending response and any request this cycle
- ld_mode  input  1  request program-load mode (level)
- ld_valid  input  1  load write strobe
- ld_addr  input  ADDR_W  byte address of the load write
- ld_data  input  DATA_W  word to write
- ld_ready  output  1  high while in LOAD; writes are accepted only then
- busy  output  1  high in BOOT, DRAIN or LOAD

## Operation
- Word index is req_pc[IDX_W+1:2], with IDX_W = log2(DEPTH).
- A fault occurs when req_pc[1:0] != 0 or req_pc >> 2 >= DEPTH. On a fault, rsp_inst = NOP (32'h0) and rsp_fault = 1. The array is not read.
- FSM states: BOOT (only with the macro), RUN, DRAIN, LOAD.
- RUN: req_ready = !flush && (!rsp_valid || rsp_ready). If ld_mode = 1 and rsp_valid = 0, go to LOAD. If ld_mode = 1 and rsp_valid = 1, go to DRAIN.
- DRAIN: req_ready = 0. Go to LOAD when the response is consumed (rsp_ready) or flushed. If ld_mode drops, go back to RUN.
- LOAD: req_ready = 0 and ld_ready = 1. Each cycle with ld_valid = 1 writes ld_data to word ld_addr[IDX_W+1:2]. A misaligned or out-of-range ld_addr is silently dropped. Go to RUN on ld_mode = 0.
- Flush has priority over a new request. rsp_valid clears on the next edge.
- A held response (rsp_valid && !rsp_ready) keeps rsp_inst and rsp_fault stable.
- Array contents are not reset. Reset clears only the control state and the outputs.

## Timing
- Reset values: rsp_valid = 0, rsp_inst = 0, rsp_fault = 0, ld_ready = 0. busy = 0 (RUN), or busy = 1 (BOOT) with INST_MEM_BOOT_EN.
- Fetch latency is 1 cycle: a request accepted at edge N gives a response valid after edge N.
- Back-to-back fetches run at 1 per cycle while rsp_ready = 1.
- A load write is visible to the first fetch after returning to RUN. Write latency is 1 cycle.
- No read/write collision can occur, because fetch is blocked in LOAD and BOOT.
- If rst asserts mid-load, the FSM aborts to RUN (or BOOT). Words already written keep their values.

## Configuration
- INST_MEM_BOOT_EN defined: after reset release, the FSM sits in BOOT for 4 cycles. It writes one word per cycle, to words 1..4 (byte 4, 8, 12, 16):
  - 32'h00641020 (add $2,$3,$4)
  - 32'h00640822 (sub $1,$3,$4)
  - 32'h8CC50000 (lw $5,0($6))
  - 32'h1064FFFD (beq $3,$4,-3)
- In BOOT, req_ready = 0 and busy = 1; the FSM then moves to RUN. ld_mode is ignored until RUN.
- INST_MEM_BOOT_EN undefined: there is no BOOT state. Reset goes straight to RUN, and the program must be written through the load port.

## Structure
- inst_mem_pkg holds:
  - the NOP constant;
  - the BOOT_PROG array of 4 words, with BOOT_BASE = 1;
  - the FSM state enum;
  - the fault helper function.
- Sub-module inst_mem_array: a DEPTH×DATA_W 1R1W memory with a synchronous write and a combinational read feeding the registered response. The top-level module owns the FSM, the handshake and the response register.

## Test plan
- Boot (macro on): release rst, wait for busy to drop after 4 cycles, then fetch pc 4, 8, 12, 16 back-to-back with rsp_ready = 1. Expect 00641020, 00640822, 8CC50000, 1064FFFD on consecutive cycles, rsp_fault = 0.
- Fault: fetch pc 6 and then pc 4·DEPTH. Both return rsp_inst = 0 and rsp_fault = 1.
- Backpressure: with rsp_ready = 0 for 3 cycles after a fetch of pc 8, expect req_ready = 0 and rsp_inst stable at 00640822. When rsp_ready = 1, the next request is accepted the same cycle.
- Flush: accept pc 12, then assert flush with req_valid = 1. Expect rsp_valid = 0 next cycle and no request accepted that cycle.
- Load with pending response: raise ld_mode while a response is held. The FSM goes to DRAIN and then LOAD after consumption. Write 32'hDEADBEEF to byte 20, drop ld_mode, then fetch pc 20 and expect DEADBEEF.
- Reset mid-load: assert rst during LOAD after one write. Expect rsp_valid = 0 and ld_ready = 0 immediately, and the written word is retained.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// Shared definitions for the fetch-stage instruction memory: NOP word,
// boot program image, controller state encoding and address fault check.
package inst_mem_pkg;

   localparam logic [31:0] NOP       = 32'h0000_0000;
   localparam int          BOOT_BASE = 1;
   localparam int          BOOT_LEN  = 4;

   // Index 0 is the first word written (lands at word BOOT_BASE).
   localparam logic [BOOT_LEN-1:0][31:0] BOOT_PROG = {
      32'h1064FFFD,   // beq $3,$4,-3
      32'h8CC50000,   // lw  $5,0($6)
      32'h00640822,   // sub $1,$3,$4
      32'h00641020    // add $2,$3,$4
   };

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_LOAD  = 2'd3
   } state_e;

   // A byte address faults when it is not word aligned or its word index
   // lies beyond the 2**idx_w words of the array.
   function automatic logic addr_fault(input logic [63:0] byte_addr, input int idx_w);
      return (byte_addr[1:0] != 2'b00) || ((byte_addr >> 2) >= (64'd1 << idx_w));
   endfunction

endpackage

// File: rtl/inst_mem_array.sv
// DEPTH x DATA_W instruction storage: synchronous write, combinational read.
// Contents are deliberately not reset so a loaded program survives rst.
module inst_mem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Write one word per cycle when enabled.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/inst_fetch_mem.sv
// Fetch-stage instruction memory with valid/ready request/response, flush,
// run-time program load port and an optional boot preloader.
// Optional feature: define INST_MEM_BOOT_EN to preload the boot program
// into words 1..4 during the 4 cycles after reset release.
module inst_fetch_mem
   import inst_mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_pc,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_inst,
   output logic              rsp_fault,
   input  logic              flush,
   input  logic              ld_mode,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              busy
);

   localparam int IDX_W = $clog2(DEPTH);

`ifdef INST_MEM_BOOT_EN
   localparam state_e RESET_STATE = ST_BOOT;
   logic [1:0] boot_cnt_q, boot_cnt_d;
`else
   localparam state_e RESET_STATE = ST_RUN;
`endif

   state_e            state_q, state_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_inst_q, rsp_inst_d;
   logic              rsp_fault_q, rsp_fault_d;

   logic              req_fault, ld_fault;
   logic [IDX_W-1:0]  rd_idx, wr_idx;
   logic [DATA_W-1:0] rd_data, wr_data;
   logic              wr_en;

   assign req_fault = addr_fault(64'(req_pc), IDX_W);
   assign ld_fault  = addr_fault(64'(ld_addr), IDX_W);
   assign rd_idx    = req_pc[IDX_W+1:2];

   // Controller: next state, handshake readiness and array write port.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      ld_ready  = 1'b0;
      busy      = 1'b1;
      wr_en     = 1'b0;
      wr_idx    = ld_addr[IDX_W+1:2];
      wr_data   = ld_data;
`ifdef INST_MEM_BOOT_EN
      boot_cnt_d = boot_cnt_q;
`endif
      case (state_q)
         ST_RUN: begin
            busy      = 1'b0;
            req_ready = !flush && (!rsp_valid_q || rsp_ready);
            if (ld_mode) begin
               state_d = rsp_valid_q ? ST_DRAIN : ST_LOAD;
            end
         end
         ST_DRAIN: begin
            if (!ld_mode) begin
               state_d = ST_RUN;
            end else if (rsp_ready || flush) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            ld_ready = 1'b1;
            wr_en    = ld_valid && !ld_fault;
            if (!ld_mode) begin
               state_d = ST_RUN;
            end
         end
         ST_BOOT: begin
`ifdef INST_MEM_BOOT_EN
            wr_en      = 1'b1;
            wr_idx     = IDX_W'(BOOT_BASE) + IDX_W'(boot_cnt_q);
            wr_data    = DATA_W'(BOOT_PROG[boot_cnt_q]);
            boot_cnt_d = boot_cnt_q + 2'd1;
            if (boot_cnt_q == 2'(BOOT_LEN - 1)) begin
               state_d = ST_RUN;
            end
`else
            state_d = ST_RUN;
`endif
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Response register: flush discards, an accepted request loads, a
   // consumed response retires, otherwise the held response stays stable.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_inst_d  = rsp_inst_q;
      rsp_fault_d = rsp_fault_q;
      if (flush) begin
         rsp_valid_d = 1'b0;
      end else if (req_valid && req_ready) begin
         rsp_valid_d = 1'b1;
         rsp_fault_d = req_fault;
         rsp_inst_d  = req_fault ? DATA_W'(NOP) : rd_data;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // Control and response state; array contents are outside this reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RESET_STATE;
         rsp_valid_q <= 1'b0;
         rsp_inst_q  <= '0;
         rsp_fault_q <= 1'b0;
`ifdef INST_MEM_BOOT_EN
         boot_cnt_q  <= 2'd0;
`endif
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_inst_q  <= rsp_inst_d;
         rsp_fault_q <= rsp_fault_d;
`ifdef INST_MEM_BOOT_EN
         boot_cnt_q  <= boot_cnt_d;
`endif
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_inst  = rsp_inst_q;
   assign rsp_fault = rsp_fault_q;

   inst_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Scoreboard bench for inst_fetch_mem: the driver queues the expected
// response of every accepted fetch, a monitor pops and compares on each
// response transfer.
module tb_inst_fetch_mem;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [ADDR_W-1:0] req_pc = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [DATA_W-1:0] rsp_inst;
   logic              rsp_fault;
   logic              flush = 1'b0;
   logic              ld_mode = 1'b0;
   logic              ld_valid = 1'b0;
   logic [ADDR_W-1:0] ld_addr = '0;
   logic [DATA_W-1:0] ld_data = '0;
   logic              ld_ready;
   logic              busy;

   always #5 clk = ~clk;

   inst_fetch_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_pc    (req_pc),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_inst  (rsp_inst),
      .rsp_fault (rsp_fault),
      .flush     (flush),
      .ld_mode   (ld_mode),
      .ld_valid  (ld_valid),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .busy      (busy)
   );

   typedef struct packed {
      logic [31:0] inst;
      logic        fault;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one fetch; queue its expected response on the accepting edge.
   task automatic fetch(input logic [31:0] pc, input logic [31:0] inst, input logic fault);
      bit   ok = 1'b0;
      exp_t e;
      req_valid = 1'b1;
      req_pc    = pc;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (req_ready) begin
            @(posedge clk);
            e.inst  = inst;
            e.fault = fault;
            exp_q.push_back(e);
            ok = 1'b1;
            #1;
         end else begin
            step();
         end
      end
      req_valid = 1'b0;
      chk("fetch_accept", 64'(ok), 64'd1);
   endtask

   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (!busy) ok = 1'b1;
      end
      chk(name, 64'(ok), 64'd1);
      step();
   endtask

   task automatic enter_load(input string name);
      bit ok = 1'b0;
      ld_mode = 1'b1;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (ld_ready) ok = 1'b1;
      end
      chk(name, 64'(ok), 64'd1);
      step();
   endtask

   task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
      ld_valid = 1'b1;
      ld_addr  = addr;
      ld_data  = data;
      step();
      ld_valid = 1'b0;
   endtask

   // Monitor: every response transfer must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst && rsp_valid && rsp_ready && !flush) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 64'(rsp_inst), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_inst", 64'(rsp_inst), 64'(e.inst));
            chk("rsp_fault", 64'(rsp_fault), 64'(e.fault));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_rsp_inst", 64'(rsp_inst), 64'd0);
      chk("reset_rsp_fault", 64'(rsp_fault), 64'd0);
      chk("reset_ld_ready", 64'(ld_ready), 64'd0);
`ifdef INST_MEM_BOOT_EN
      chk("reset_busy", 64'(busy), 64'd1);
`else
      chk("reset_busy", 64'(busy), 64'd0);
`endif
      @(posedge clk);
      #1 rst = 1'b1;

`ifdef INST_MEM_BOOT_EN
      wait_idle("boot_done");
`else
      enter_load("load_boot_enter");
      load_word(32'd4,  32'h00641020);
      load_word(32'd8,  32'h00640822);
      load_word(32'd12, 32'h8CC50000);
      load_word(32'd16, 32'h1064FFFD);
      ld_mode = 1'b0;
      wait_idle("load_boot_exit");
`endif

      // Back-to-back program fetch.
      rsp_ready = 1'b1;
      fetch(32'd4,  32'h00641020, 1'b0);
      fetch(32'd8,  32'h00640822, 1'b0);
      fetch(32'd12, 32'h8CC50000, 1'b0);
      fetch(32'd16, 32'h1064FFFD, 1'b0);

      // Misaligned and out-of-range fetches.
      fetch(32'd6, 32'h0, 1'b1);
      fetch(32'(4 * DEPTH), 32'h0, 1'b1);
      step();

      // Backpressure holds the response and blocks new requests.
      rsp_ready = 1'b0;
      fetch(32'd8, 32'h00640822, 1'b0);
      req_valid = 1'b1;
      req_pc    = 32'd12;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_req_ready", 64'(req_ready), 64'd0);
         chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
         chk("bp_rsp_inst", 64'(rsp_inst), 64'h00640822);
         step();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 64'(req_ready), 64'd1);
      @(posedge clk);
      if (req_ready) exp_q.push_back({32'h8CC50000, 1'b0});
      #1 req_valid = 1'b0;
      step();

      // Flush beats a simultaneous request and kills the pending response.
      rsp_ready = 1'b0;
      fetch(32'd12, 32'h8CC50000, 1'b0);
      flush     = 1'b1;
      req_valid = 1'b1;
      req_pc    = 32'd16;
      @(negedge clk);
      chk("flush_req_ready", 64'(req_ready), 64'd0);
      if (exp_q.size() != 0) void'(exp_q.pop_back());
      step();
      flush     = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      chk("flush_rsp_valid", 64'(rsp_valid), 64'd0);
      step();

      // Load request while a response is held: DRAIN, then LOAD.
      fetch(32'd16, 32'h1064FFFD, 1'b0);
      ld_mode = 1'b1;
      @(negedge clk);
      chk("drain_pre_busy", 64'(busy), 64'd0);
      step();
      @(negedge clk);
      chk("drain_busy", 64'(busy), 64'd1);
      chk("drain_ld_ready", 64'(ld_ready), 64'd0);
      chk("drain_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("drain_req_ready", 64'(req_ready), 64'd0);
      step();
      rsp_ready = 1'b1;
      step();
      @(negedge clk);
      chk("load_ld_ready", 64'(ld_ready), 64'd1);
      chk("load_rsp_valid", 64'(rsp_valid), 64'd0);
      step();
      load_word(32'd20, 32'hDEADBEEF);
      load_word(32'd22, 32'h12345678);
      ld_mode = 1'b0;
      wait_idle("load1_exit");
      fetch(32'd20, 32'hDEADBEEF, 1'b0);
      step();

      // Reset in the middle of a load keeps already written words.
      enter_load("load2_enter");
      load_word(32'd24, 32'hCAFEF00D);
      rst = 1'b0;
      #1;
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_ld_ready", 64'(ld_ready), 64'd0);
      ld_mode = 1'b0;
      step();
      rst = 1'b1;
`ifdef INST_MEM_BOOT_EN
      wait_idle("reboot_done");
`endif
      fetch(32'd24, 32'hCAFEF00D, 1'b0);
      fetch(32'd20, 32'hDEADBEEF, 1'b0);
      step();
      step();
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
